// File: rtl/core_pkg.sv
// Shared types for the core pipeline control: hazard FSM encoding and the
// stall/flush control bundle driven toward the pipeline registers.
package core_pkg;

  localparam int unsigned RegAwDef = 4;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } hz_state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic flush_if_id;
    logic bubble_id_exe;
    logic freeze_mem;
  } ctrl_t;

  localparam ctrl_t CtrlNone   = '{stall_pc: 1'b0, stall_if_id: 1'b0, flush_if_id: 1'b0,
                                   bubble_id_exe: 1'b0, freeze_mem: 1'b0};
  localparam ctrl_t CtrlFreeze = '{stall_pc: 1'b1, stall_if_id: 1'b1, flush_if_id: 1'b0,
                                   bubble_id_exe: 1'b0, freeze_mem: 1'b1};
  localparam ctrl_t CtrlFlush  = '{stall_pc: 1'b0, stall_if_id: 1'b0, flush_if_id: 1'b1,
                                   bubble_id_exe: 1'b1, freeze_mem: 1'b0};
  localparam ctrl_t CtrlStall  = '{stall_pc: 1'b1, stall_if_id: 1'b1, flush_if_id: 1'b0,
                                   bubble_id_exe: 1'b1, freeze_mem: 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID/EXE/MEM pipeline registers and the hazard/stall controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_AW = core_pkg::RegAwDef,
  parameter int unsigned STAT_W = 16
);
  logic              fwd_en;
  logic              id_valid;
  logic              id_two_src;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_read;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic              mem_req;
  logic              mem_ready;
  logic              branch_taken;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              bubble_id_exe;
  logic              freeze_mem;
  logic [STAT_W-1:0] stall_cycles;
  logic              mem_timeout;

  modport master (
    output fwd_en, id_valid, id_two_src, id_src1, id_src2, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
    input  stall_pc, stall_if_id, flush_if_id, bubble_id_exe, freeze_mem, stall_cycles,
           mem_timeout
  );

  modport slave (
    input  fwd_en, id_valid, id_two_src, id_src1, id_src2, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
    output stall_pc, stall_if_id, flush_if_id, bubble_id_exe, freeze_mem, stall_cycles,
           mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl_match.sv
// Combinational RAW detection between the ID sources and the EXE/MEM destinations.
module hazard_stall_ctrl_match #(
  parameter int unsigned REG_AW = 4
) (
  input  logic              fwd_en,
  input  logic              id_valid,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  output logic              data_hz
);

  logic exe_match;
  logic mem_match;

  always_comb begin
    exe_match = id_valid & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));
    mem_match = id_valid & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (fwd_en) begin
      data_hz = exe_mem_read & exe_wb_en & exe_match;
    end else begin
      data_hz = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: freeze on data-memory wait, flush on taken branch,
// stall on data hazard, plus stall-cycle statistics and a sticky memory-timeout flag.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned STAT_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  hz_state_t         state_q, state_d, state_eff;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              timeout_q, timeout_d;
  logic              data_hz;
  logic              freeze;
  ctrl_t             ctrl;

  hazard_stall_ctrl_match #(
    .REG_AW (REG_AW)
  ) u_match (
    .fwd_en       (bus.fwd_en),
    .id_valid     (bus.id_valid),
    .id_two_src   (bus.id_two_src),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .data_hz      (data_hz)
  );

  // While reset is held the outputs behave as if the FSM were already in RUN.
  assign state_eff = rst ? state_q : StRun;

  always_comb begin
    state_d = state_eff;
    freeze  = 1'b0;
    unique case (state_eff)
      StRun: begin
        freeze = bus.mem_req & ~bus.mem_ready;
        if (bus.mem_req && !bus.mem_ready) state_d = StMemWait;
      end
      StMemWait: begin
        freeze = ~bus.mem_ready;
        if (bus.mem_ready) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    ctrl = CtrlNone;
    if (freeze) begin
      ctrl = CtrlFreeze;
    end else if (bus.branch_taken) begin
      ctrl = CtrlFlush;
    end else if (data_hz) begin
      ctrl = CtrlStall;
    end
  end

  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    timeout_d      = timeout_q;
    if (state_q == StRun) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitW'(TIMEOUT)) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
    if (state_q == StMemWait && wait_cnt_q == WaitW'(TIMEOUT - 1) && !bus.mem_ready) begin
      timeout_d = 1'b1;
    end
    if (ctrl.stall_pc && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.stall_pc      = ctrl.stall_pc;
  assign bus.stall_if_id   = ctrl.stall_if_id;
  assign bus.flush_if_id   = ctrl.flush_if_id;
  assign bus.bubble_id_exe = ctrl.bubble_id_exe;
  assign bus.freeze_mem    = ctrl.freeze_mem;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.mem_timeout   = timeout_q;

endmodule
